// File: rtl/reg_bank_param.sv
// Parametrised register bank with one in-place modify port, two combinational read ports
// and registered carry/zero flags from the last executed operation.
module reg_bank_param #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       NUM_REGS    = 4,
    parameter bit                BYPASS      = 1'b1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    localparam int unsigned      AW          = $clog2(NUM_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             carry_out,
    output logic             zero_out
);

    typedef enum logic [2:0] {
        OpHold  = 3'b000,
        OpLoad  = 3'b001,
        OpClear = 3'b010,
        OpInc   = 3'b011,
        OpDec   = 3'b100,
        OpShl   = 3'b101,
        OpShr   = 3'b110,
        OpAdd   = 3'b111
    } op_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             addr_ok;
    logic             executes;
    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] result;
    logic             result_c;
    logic [WIDTH:0]   sum;

    assign addr_ok  = 32'(wr_addr) < NUM_REGS;
    assign executes = wr_en && (op_e'(op) != OpHold) && addr_ok;

    // Out-of-range addresses never select a register, so the mux defaults to zero.
    always_comb begin
        cur_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(wr_addr) == i) begin
                cur_val = regs_q[i];
            end
        end
    end

    always_comb begin
        result   = cur_val;
        result_c = carry_q;
        sum      = '0;
        unique case (op_e'(op))
            OpHold: begin
                result   = cur_val;
                result_c = carry_q;
            end
            OpLoad: begin
                result   = wr_data;
                result_c = 1'b0;
            end
            OpClear: begin
                result   = '0;
                result_c = 1'b0;
            end
            OpInc: begin
                sum      = {1'b0, cur_val} + {{WIDTH{1'b0}}, 1'b1};
                result   = sum[WIDTH-1:0];
                result_c = sum[WIDTH];
            end
            OpDec: begin
                result   = cur_val - {{(WIDTH-1){1'b0}}, 1'b1};
                result_c = (cur_val == '0);
            end
            OpShl: begin
                result   = {cur_val[WIDTH-2:0], wr_data[0]};
                result_c = cur_val[WIDTH-1];
            end
            OpShr: begin
                result   = {wr_data[0], cur_val[WIDTH-1:1]};
                result_c = cur_val[0];
            end
            OpAdd: begin
                sum      = {1'b0, cur_val} + {1'b0, wr_data};
                result   = sum[WIDTH-1:0];
                result_c = sum[WIDTH];
            end
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        carry_d = carry_q;
        zero_d  = zero_q;
        if (executes) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(wr_addr) == i) begin
                    regs_d[i] = result;
                end
            end
            carry_d = result_c;
            zero_d  = (result == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
            carry_q <= 1'b0;
            zero_q  <= (RESET_VALUE == '0);
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // Reads forward the in-flight result only when bypass is enabled.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_addr_a) == i) begin
                rd_data_a = (BYPASS && executes && (wr_addr == rd_addr_a)) ? result : regs_q[i];
            end
            if (32'(rd_addr_b) == i) begin
                rd_data_b = (BYPASS && executes && (wr_addr == rd_addr_b)) ? result : regs_q[i];
            end
        end
    end

    assign carry_out = carry_q;
    assign zero_out  = zero_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: three instances (bypass, no bypass, 3 regs with nonzero reset)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_reg_bank_param;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] op;
    logic [7:0] wr_data;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;

    logic [7:0] rda [3];
    logic [7:0] rdb [3];
    logic       co  [3];
    logic       zo  [3];

    int vectors;
    int miscompares;

    int nregs [3] = '{4, 4, 3};
    bit byp   [3] = '{1'b1, 1'b0, 1'b1};
    int rstv  [3] = '{0, 0, 'h5A};
    int mem   [3][4];
    int carry [3];
    int zero  [3];

    reg_bank_param #(.WIDTH(8), .NUM_REGS(4), .BYPASS(1'b1), .RESET_VALUE(8'h00)) u_byp (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .op(op),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .carry_out(co[0]), .zero_out(zo[0])
    );

    reg_bank_param #(.WIDTH(8), .NUM_REGS(4), .BYPASS(1'b0), .RESET_VALUE(8'h00)) u_nobyp (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .op(op),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .carry_out(co[1]), .zero_out(zo[1])
    );

    reg_bank_param #(.WIDTH(8), .NUM_REGS(3), .BYPASS(1'b1), .RESET_VALUE(8'h5A)) u_three (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .op(op),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[2]), .rd_data_b(rdb[2]), .carry_out(co[2]), .zero_out(zo[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        logic [7:0] e;
        e = 8'(exp);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Reference arithmetic on plain integers in 0..255.
    task automatic model_op(input int opc, input int r, input int d, output int res, output int c);
        int s;
        res = r;
        c   = 0;
        case (opc)
            1: begin res = d; c = 0; end
            2: begin res = 0; c = 0; end
            3: begin s = r + 1; res = s % 256; c = (s >= 256) ? 1 : 0; end
            4: begin res = (r + 255) % 256; c = (r == 0) ? 1 : 0; end
            5: begin res = (r * 2 + d % 2) % 256; c = (r >= 128) ? 1 : 0; end
            6: begin res = (d % 2) * 128 + r / 2; c = r % 2; end
            7: begin s = r + d; res = s % 256; c = (s >= 256) ? 1 : 0; end
            default: begin res = r; c = 0; end
        endcase
    endtask

    function automatic int read_exp(input int k, input int ra, input bit exe, input int wa,
                                    input int res);
        if (ra >= nregs[k]) return 0;
        if (byp[k] && exe && (wa == ra)) return res;
        return mem[k][ra];
    endfunction

    task automatic step(input bit rst, input bit en, input int addr, input int opc, input int data,
                        input int ra, input int rb);
        int  res [3];
        int  c   [3];
        bit  exe [3];
        int  cur;
        @(negedge clock);
        reset     = rst;
        wr_en     = en;
        wr_addr   = 2'(addr);
        op        = 3'(opc);
        wr_data   = 8'(data);
        rd_addr_a = 2'(ra);
        rd_addr_b = 2'(rb);
        #1;
        for (int k = 0; k < 3; k++) begin
            exe[k] = en && (opc != 0) && (addr < nregs[k]);
            cur    = (addr < nregs[k]) ? mem[k][addr] : 0;
            model_op(opc, cur, data, res[k], c[k]);
            if (!rst) begin
                chk($sformatf("dut%0d rd_a[%0d]", k, ra), rda[k],
                    read_exp(k, ra, exe[k], addr, res[k]));
                chk($sformatf("dut%0d rd_b[%0d]", k, rb), rdb[k],
                    read_exp(k, rb, exe[k], addr, res[k]));
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) mem[k][i] = rstv[k];
                carry[k] = 0;
                zero[k]  = (rstv[k] == 0) ? 1 : 0;
            end else if (exe[k]) begin
                mem[k][addr] = res[k];
                carry[k]     = c[k];
                zero[k]      = (res[k] == 0) ? 1 : 0;
            end
            chk($sformatf("dut%0d carry", k), {7'b0, co[k]}, carry[k]);
            chk($sformatf("dut%0d zero", k), {7'b0, zo[k]}, zero[k]);
        end
    endtask

    task automatic sweep();
        for (int a = 0; a < 4; a++) step(1'b0, 1'b0, 0, 0, 0, a, 3 - a);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) mem[k][i] = 0;
            carry[k] = 0;
            zero[k]  = 0;
        end
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; op = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;

        // Reset, read everything, then a first LOAD.
        step(1'b1, 1'b0, 0, 0, 0, 0, 0);
        sweep();
        step(1'b0, 1'b1, 2, 1, 'hA5, 2, 0);
        sweep();

        // LOAD, INC twice through the wrap, DEC back.
        step(1'b0, 1'b1, 1, 1, 'hFE, 1, 2);
        step(1'b0, 1'b1, 1, 3, 0, 1, 0);
        step(1'b0, 1'b1, 1, 3, 0, 1, 0);
        step(1'b0, 1'b1, 1, 4, 0, 1, 0);
        step(1'b0, 1'b0, 0, 0, 0, 1, 0);

        // Shifts with serial-in.
        step(1'b0, 1'b1, 0, 1, 'h81, 0, 1);
        step(1'b0, 1'b1, 0, 5, 'h01, 0, 1);
        step(1'b0, 1'b1, 0, 6, 'h00, 0, 1);

        // ADD with carry, then gated-off ADD and HOLD.
        step(1'b0, 1'b1, 3, 1, 'hC0, 3, 3);
        step(1'b0, 1'b1, 3, 7, 'h50, 3, 3);
        step(1'b0, 1'b0, 3, 7, 'h50, 3, 2);
        step(1'b0, 1'b1, 3, 0, 'h50, 3, 2);

        // Bypass on both ports of the same register.
        step(1'b0, 1'b1, 2, 1, 'h3C, 2, 2);
        step(1'b0, 1'b0, 0, 0, 0, 2, 2);

        // Reset colliding with a write, then out-of-range write on the 3-register bank.
        step(1'b0, 1'b1, 0, 1, 'h11, 0, 0);
        step(1'b1, 1'b1, 0, 1, 'h55, 0, 0);
        sweep();
        step(1'b0, 1'b1, 3, 1, 'h77, 3, 3);
        step(1'b0, 1'b1, 3, 3, 0, 3, 2);
        sweep();

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
